// File: rtl/calc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | calc_sequencer: sequences operand A, operator, operand B, '=' into   |
// | one ALU start and one print handshake; sticky error until CLEAR.     |
// | Option macro: CALC_SEQ_CHAIN_EN (result feeds next operand A).       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module calc_sequencer #(
  parameter int NUM_W   = 10,
  parameter int RES_W   = 20,
  parameter int TMO_CYC = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tok_valid,
  input  logic [2:0]       tok_mode,
  input  logic [1:0]       tok_check,
  input  logic [NUM_W-1:0] tok_num,
  output logic [NUM_W-1:0] op_a,
  output logic [NUM_W-1:0] op_b,
  output logic [2:0]       alu_op,
  output logic             alu_start,
  input  logic             alu_done,
  input  logic [RES_W-1:0] alu_result,
  output logic             print_en,
  input  logic             print_ready,
  output logic [RES_W-1:0] print_data,
  output logic             err,
  output logic             busy
);

  localparam int               CNT_W    = $clog2(TMO_CYC + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);
  localparam logic [2:0]       M_NUM    = 3'd0;
  localparam logic [2:0]       M_CLEAR  = 3'd5;
  localparam logic [2:0]       M_RSVD   = 3'd7;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_GOT_A  = 4'd1,
    S_GOT_OP = 4'd2,
    S_GOT_B  = 4'd3,
    S_EXEC   = 4'd4,
    S_WAIT   = 4'd5,
    S_PRINT  = 4'd6,
    S_ERROR  = 4'd7
`ifdef CALC_SEQ_CHAIN_EN
    ,S_CHAIN = 4'd8
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [NUM_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic [RES_W-1:0] print_data_q, print_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tok_clear, tok_bad, is_num, is_oper;

  // CLEAR is honoured whatever the check field says.
  assign tok_clear = tok_valid && (tok_mode == M_CLEAR);
  assign tok_bad   = (tok_check != 2'b01) || (tok_mode == M_RSVD);
  assign is_num    = (tok_mode == M_NUM);
  assign is_oper   = (tok_mode >= 3'd1) && (tok_mode <= 3'd4);

  always_comb begin
    state_d      = state_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    alu_op_d     = alu_op_q;
    print_data_d = print_data_q;
    cnt_d        = '0;
    if (tok_clear) begin
      state_d      = S_IDLE;
      op_a_d       = '0;
      op_b_d       = '0;
      alu_op_d     = '0;
      print_data_d = '0;
    end else begin
      case (state_q)
        S_IDLE: if (tok_valid) begin
          if (!tok_bad && is_num) begin
            op_a_d  = tok_num;
            state_d = S_GOT_A;
          end else state_d = S_ERROR;
        end
        S_GOT_A: if (tok_valid) begin
          if (tok_bad) state_d = S_ERROR;
          else if (is_num) op_a_d = tok_num;
          else if (is_oper) begin
            alu_op_d = tok_mode;
            state_d  = S_GOT_OP;
          end else state_d = S_ERROR;
        end
        S_GOT_OP: if (tok_valid) begin
          if (tok_bad) state_d = S_ERROR;
          else if (is_num) begin
            op_b_d  = tok_num;
            state_d = S_GOT_B;
          end else if (is_oper) alu_op_d = tok_mode;
          else state_d = S_ERROR;
        end
        S_GOT_B: if (tok_valid) begin
          if (tok_bad || is_oper) state_d = S_ERROR;
          else if (is_num) op_b_d = tok_num;
          else state_d = S_EXEC;
        end
        S_EXEC: state_d = S_WAIT;
        // A done arriving on the final count still wins over the timeout.
        S_WAIT: begin
          if (alu_done) begin
            print_data_d = alu_result;
            state_d      = S_PRINT;
          end else if (cnt_q == TMO_LAST) state_d = S_ERROR;
          else cnt_d = cnt_q + 1'b1;
        end
        S_PRINT: if (print_ready) begin
`ifdef CALC_SEQ_CHAIN_EN
          state_d = S_CHAIN;
`else
          state_d = S_IDLE;
`endif
        end
`ifdef CALC_SEQ_CHAIN_EN
        S_CHAIN: if (tok_valid) begin
          if (tok_bad) state_d = S_ERROR;
          else if (is_num) begin
            op_a_d  = tok_num;
            state_d = S_GOT_A;
          end else if (is_oper) begin
            if (|print_data_q[RES_W-1:NUM_W]) state_d = S_ERROR;
            else begin
              op_a_d   = print_data_q[NUM_W-1:0];
              alu_op_d = tok_mode;
              state_d  = S_GOT_OP;
            end
          end else state_d = S_ERROR;
        end
`endif
        S_ERROR: state_d = S_ERROR;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_a_q       <= '0;
      op_b_q       <= '0;
      alu_op_q     <= '0;
      print_data_q <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      alu_op_q     <= alu_op_d;
      print_data_q <= print_data_d;
      cnt_q        <= cnt_d;
    end
  end

  assign op_a       = op_a_q;
  assign op_b       = op_b_q;
  assign alu_op     = alu_op_q;
  assign print_data = print_data_q;
  assign alu_start  = (state_q == S_EXEC);
  assign print_en   = (state_q == S_PRINT);
  assign err        = (state_q == S_ERROR);
  assign busy       = (state_q == S_EXEC) || (state_q == S_WAIT) || (state_q == S_PRINT);

endmodule
`default_nettype wire

// File: tb/tb_calc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_calc_sequencer: directed tokens with a scoreboard on ALU start    |
// | and print handshakes. Rev 1.0                                        |
// +----------------------------------------------------------------------+
module tb_calc_sequencer;
  localparam int NUM_W = 10;
  localparam int RES_W = 20;
  localparam int TMO_CYC = 1023;

  logic clk = 1'b0, rst = 1'b1;
  logic tok_valid = 1'b0;
  logic [2:0] tok_mode = '0;
  logic [1:0] tok_check = 2'b01;
  logic [NUM_W-1:0] tok_num = '0;
  logic [NUM_W-1:0] op_a, op_b;
  logic [2:0] alu_op;
  logic alu_start, alu_done, print_en, err, busy;
  logic print_ready = 1'b1;
  logic [RES_W-1:0] alu_result, print_data;

  int n_pass = 0, n_total = 0;
  logic [22:0] exp_start[$];
  logic [RES_W-1:0] exp_print[$];
  bit alu_en = 1'b1;
  int alu_delay = 0;
  logic [RES_W-1:0] alu_res = '0;

  calc_sequencer #(.NUM_W(NUM_W), .RES_W(RES_W), .TMO_CYC(TMO_CYC)) dut (
    .clk(clk), .rst(rst), .tok_valid(tok_valid), .tok_mode(tok_mode),
    .tok_check(tok_check), .tok_num(tok_num), .op_a(op_a), .op_b(op_b),
    .alu_op(alu_op), .alu_start(alu_start), .alu_done(alu_done),
    .alu_result(alu_result), .print_en(print_en), .print_ready(print_ready),
    .print_data(print_data), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tok(input logic [2:0] m, input logic [NUM_W-1:0] n, input logic [1:0] c);
    tok_valid = 1'b1; tok_mode = m; tok_num = n; tok_check = c;
    cycles(1);
    tok_valid = 1'b0; tok_check = 2'b01;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && busy; i++) cycles(1);
    chk("wait_idle", {63'd0, busy}, 64'd0);
  endtask

  // ALU model: returns the result the stimulus has prepared.
  initial begin
    alu_done = 1'b0; alu_result = '0;
    forever begin
      @(negedge clk);
      if (alu_start && alu_en) begin
        repeat (alu_delay) @(posedge clk);
        @(posedge clk); #1;
        alu_done = 1'b1; alu_result = alu_res;
        @(posedge clk); #1;
        alu_done = 1'b0;
      end
    end
  end

  // Monitor: every start and every print handshake must match a queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && alu_start) begin
        if (exp_start.size() == 0) chk("start_unexpected", 64'd1, 64'd0);
        else chk("start_ops", {41'd0, op_a, op_b, alu_op}, {41'd0, exp_start.pop_front()});
      end
      if (!rst && print_en && print_ready) begin
        if (exp_print.size() == 0) chk("print_unexpected", 64'd1, 64'd0);
        else chk("print_data", {44'd0, print_data}, {44'd0, exp_print.pop_front()});
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cycles(3);
    rst = 1'b0;
    cycles(1);
    chk("rst_op_a", {54'd0, op_a}, 64'd0);
    chk("rst_op_b", {54'd0, op_b}, 64'd0);
    chk("rst_flags", {58'd0, alu_op, alu_start, print_en, err}, 64'd0);
    chk("rst_busy_pd", {43'd0, busy, print_data}, 64'd0);

    // 3 + 6 = 9, checking the start latency.
    alu_res = 20'd9; alu_delay = 0;
    exp_start.push_back({10'd3, 10'd6, 3'd1}); exp_print.push_back(20'd9);
    tok(3'd0, 10'd3, 2'b01); tok(3'd1, 10'd0, 2'b01);
    tok(3'd0, 10'd6, 2'b01); tok(3'd6, 10'd0, 2'b01);
    chk("start_latency", {63'd0, alu_start}, 64'd1);
    wait_idle();
    chk("idle_after_print", {61'd0, print_en, err, busy}, 64'd0);

    // Last number wins, operator replaced.
    alu_res = 20'd5; alu_delay = 3;
    exp_start.push_back({10'd7, 10'd2, 3'd2}); exp_print.push_back(20'd5);
    tok(3'd0, 10'd5, 2'b01); tok(3'd0, 10'd7, 2'b01);
    tok(3'd3, 10'd0, 2'b01); tok(3'd2, 10'd0, 2'b01);
    tok(3'd0, 10'd2, 2'b01); tok(3'd6, 10'd0, 2'b01);
    wait_idle();

    // Operator in IDLE is an error; NUM is then ignored; CLEAR recovers.
    tok(3'd1, 10'd0, 2'b01);
    chk("err_op_in_idle", {63'd0, err}, 64'd1);
    tok(3'd0, 10'd4, 2'b01);
    chk("err_sticky", {63'd0, err}, 64'd1);
    chk("err_num_ignored", {54'd0, op_a}, 64'd7);
    tok(3'd5, 10'd0, 2'b01);
    chk("clear_flags", {59'd0, err, busy, print_en, alu_start, 1'b0}, 64'd0);
    chk("clear_regs", {21'd0, op_a, op_b, alu_op, print_data}, 64'd0);

    // Timeout with alu_done withheld.
    alu_en = 1'b0;
    exp_start.push_back({10'd1, 10'd1, 3'd1});
    tok(3'd0, 10'd1, 2'b01); tok(3'd1, 10'd0, 2'b01);
    tok(3'd0, 10'd1, 2'b01); tok(3'd6, 10'd0, 2'b01);
    cycles(TMO_CYC - 23);
    chk("tmo_still_wait", {62'd0, busy, err}, 64'd2);
    cycles(40);
    chk("tmo_err", {62'd0, err, print_en}, 64'd2);
    tok(3'd5, 10'd0, 2'b01);
    alu_en = 1'b1;

    // Bad check field in GOT_A.
    tok(3'd0, 10'd8, 2'b01); tok(3'd0, 10'd9, 2'b10);
    chk("bad_check_err", {63'd0, err}, 64'd1);
    tok(3'd5, 10'd0, 2'b01);
    chk("bad_check_clear", {63'd0, err}, 64'd0);

    // Printer back-pressure: print_en and data hold.
    print_ready = 1'b0; alu_res = 20'd1; alu_delay = 0;
    exp_start.push_back({10'd2, 10'd1, 3'd2}); exp_print.push_back(20'd1);
    tok(3'd0, 10'd2, 2'b01); tok(3'd2, 10'd0, 2'b01);
    tok(3'd0, 10'd1, 2'b01); tok(3'd6, 10'd0, 2'b01);
    cycles(2);
    chk("print_latency", {43'd0, print_en, print_data}, {43'd0, 1'b1, 20'd1});
    for (int i = 0; i < 5; i++) begin
      cycles(1);
      chk("print_hold", {43'd0, print_en, print_data}, {43'd0, 1'b1, 20'd1});
    end
    print_ready = 1'b1;
    cycles(1);
    chk("print_release", {62'd0, print_en, busy}, 64'd0);

    // Asynchronous reset mid-WAIT.
    alu_en = 1'b0;
    exp_start.push_back({10'd4, 10'd3, 3'd3});
    tok(3'd0, 10'd4, 2'b01); tok(3'd3, 10'd0, 2'b01);
    tok(3'd0, 10'd3, 2'b01); tok(3'd6, 10'd0, 2'b01);
    cycles(3);
    chk("wait_busy", {63'd0, busy}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst", {17'd0, op_a, op_b, alu_op, alu_start, print_en, err, busy, print_data}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    alu_en = 1'b1;
    cycles(1);

    // After a print, an operator either chains or errors.
    alu_res = 20'd9; alu_delay = 1;
    exp_start.push_back({10'd3, 10'd6, 3'd1}); exp_print.push_back(20'd9);
    tok(3'd0, 10'd3, 2'b01); tok(3'd1, 10'd0, 2'b01);
    tok(3'd0, 10'd6, 2'b01); tok(3'd6, 10'd0, 2'b01);
    wait_idle();
`ifdef CALC_SEQ_CHAIN_EN
    alu_res = 20'd5;
    exp_start.push_back({10'd9, 10'd4, 3'd2}); exp_print.push_back(20'd5);
    tok(3'd2, 10'd0, 2'b01); tok(3'd0, 10'd4, 2'b01); tok(3'd6, 10'd0, 2'b01);
    wait_idle();
    chk("chain_no_err", {63'd0, err}, 64'd0);
`else
    tok(3'd2, 10'd0, 2'b01);
    chk("no_chain_err", {63'd0, err}, 64'd1);
    tok(3'd5, 10'd0, 2'b01);
`endif

    cycles(5);
    chk("start_queue_empty", 64'(exp_start.size()), 64'd0);
    chk("print_queue_empty", 64'(exp_print.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
